// File: rtl/chat_filter_multi.sv
// ---------------------------------------------------------------------------
// chat_filter_multi
//
// Multi-channel chatter filter for slow asynchronous inputs such as switches,
// limit sensors and encoder index lines. Each channel works as follows:
//   - DIN is synchronised through SYNC_STAGES flops on every clock.
//   - The synchronised value is shifted into a DEPTH-deep sample window on
//     each CE strobe.
//   - The window is resolved into a level, either by majority vote (MODE=0)
//     or by an all-agree hysteresis rule (MODE=1).
// The level and its rise/fall pulses are registered on every clock.
//
// Parameters
//   CH          number of independent channels (1..32)
//   DEPTH       samples held per channel (odd, 3..15)
//   SYNC_STAGES synchroniser depth (2..3)
//   INIT_VAL    reset value of synchroniser, samples and DOUT
//
// Ports
//   CLK       clock, rising edge
//   RST_N     asynchronous active-low reset
//   CE        sample strobe (single-cycle pulse or held high)
//   MODE      0 = majority vote, 1 = all-agree hysteresis (not registered)
//   DIN       raw asynchronous inputs, one bit per channel
//   DOUT      filtered level per channel, registered
//   RISE      one-clock pulse on a DOUT 0->1 transition, registered
//   FALL      one-clock pulse on a DOUT 1->0 transition, registered
//   ANY_EDGE  OR of all RISE|FALL bits, combinational from registers
// ---------------------------------------------------------------------------
module chat_filter_multi #(
  parameter int unsigned CH          = 8,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT_VAL    = 1'b0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE,
  input  logic          MODE,
  input  logic [CH-1:0] DIN,
  output logic [CH-1:0] DOUT,
  output logic [CH-1:0] RISE,
  output logic [CH-1:0] FALL,
  output logic          ANY_EDGE
);

  localparam int unsigned ONES_W = $clog2(DEPTH + 1);
  localparam int unsigned THR    = (DEPTH + 1) / 2;

  localparam logic [ONES_W-1:0] THR_C   = ONES_W'(THR);
  localparam logic [ONES_W-1:0] DEPTH_C = ONES_W'(DEPTH);
  localparam logic [ONES_W-1:0] ZERO_C  = '0;

  // Elaboration-time parameter legality checks
  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("chat_filter_multi: CH must be 1..32");
  end
  if (DEPTH < 3 || DEPTH > 15 || (DEPTH % 2) == 0) begin : g_bad_depth
    $error("chat_filter_multi: DEPTH must be odd, 3..15");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("chat_filter_multi: SYNC_STAGES must be 2..3");
  end

  // Per-channel state
  logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CH-1:0][DEPTH-1:0]       smp_q, smp_d;
  logic [CH-1:0]                  dout_q, dout_d;
  logic [CH-1:0]                  rise_q, rise_d;
  logic [CH-1:0]                  fall_q, fall_d;

  // Combinational helpers
  logic [CH-1:0]                  sync_last;
  logic [CH-1:0][ONES_W-1:0]      ones;

  // Number of ones held in one sample window
  function automatic logic [ONES_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [ONES_W-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      c = c + ONES_W'(v[k]);
    end
    return c;
  endfunction

  // Synchroniser shift, free-running on every clock
  always_comb begin
    sync_d    = sync_q;
    sync_last = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], DIN[i]};
      sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Sample window shift, advanced only on CE
  always_comb begin
    smp_d = smp_q;
    if (CE) begin
      for (int unsigned i = 0; i < CH; i++) begin
        smp_d[i] = {smp_q[i][DEPTH-2:0], sync_last[i]};
      end
    end
  end

  // Level decision and edge pulses; evaluated every clock, ungated by CE
  always_comb begin
    ones   = '0;
    dout_d = dout_q;
    for (int unsigned i = 0; i < CH; i++) begin
      ones[i] = popcount(smp_q[i]);
      if (MODE) begin
        // Hysteresis: only a unanimous window moves the level
        if (ones[i] == DEPTH_C) begin
          dout_d[i] = 1'b1;
        end else if (ones[i] == ZERO_C) begin
          dout_d[i] = 1'b0;
        end else begin
          dout_d[i] = dout_q[i];
        end
      end else begin
        // DEPTH is odd, so the threshold never ties
        dout_d[i] = (ones[i] >= THR_C);
      end
    end
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= {(CH * SYNC_STAGES){INIT_VAL}};
      smp_q  <= {(CH * DEPTH){INIT_VAL}};
      dout_q <= {CH{INIT_VAL}};
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      smp_q  <= smp_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign DOUT     = dout_q;
  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign ANY_EDGE = |(rise_q | fall_q);

endmodule

// File: tb/tb_chat_filter_multi.sv
// ---------------------------------------------------------------------------
// tb_chat_filter_multi
//
// Directed bench for chat_filter_multi. u_dut uses the default parameters
// (CH=8, DEPTH=3, SYNC_STAGES=2). u_dut5 uses DEPTH=5 in hysteresis mode.
// Inputs are driven 1 time unit after a rising edge, so the next rising
// edge is "edge 1". Outputs are sampled at that same offset.
// ---------------------------------------------------------------------------
module tb_chat_filter_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       mode;
  logic       mode5;
  logic [7:0] din;
  logic [7:0] din5;
  logic [7:0] dout, rise, fall;
  logic [7:0] dout5, rise5, fall5;
  logic       any_edge, any_edge5;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] acc;
  logic [7:0] acc5;

  always #5 clk = ~clk;

  chat_filter_multi #(
    .CH(8), .DEPTH(3), .SYNC_STAGES(2), .INIT_VAL(1'b0)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .MODE(mode), .DIN(din),
    .DOUT(dout), .RISE(rise), .FALL(fall), .ANY_EDGE(any_edge)
  );

  chat_filter_multi #(
    .CH(8), .DEPTH(5), .SYNC_STAGES(2), .INIT_VAL(1'b0)
  ) u_dut5 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .MODE(mode5), .DIN(din5),
    .DOUT(dout5), .RISE(rise5), .FALL(fall5), .ANY_EDGE(any_edge5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset with all inputs high
    rst_n = 1'b0; ce = 1'b1; mode = 1'b0; mode5 = 1'b1;
    din = 8'hFF; din5 = 8'hFF;
    repeat (3) tick();
    check("rst_dout",     32'(dout),     32'h00);
    check("rst_rise",     32'(rise),     32'h00);
    check("rst_fall",     32'(fall),     32'h00);
    check("rst_any_edge", 32'(any_edge), 32'h0);
    check("rst_dout5",    32'(dout5),    32'h00);

    din = 8'h00; din5 = 8'h00; rst_n = 1'b1;
    acc = '0;
    for (int e = 0; e < 20; e++) begin
      tick();
      acc |= rise | fall | rise5 | fall5 | dout | dout5;
    end
    check("rel_no_pulse", 32'(acc), 32'h00);

    // ---------------- majority latency, channel 0
    din = 8'h01;
    acc = '0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      acc |= dout | rise | fall;
    end
    check("maj_early", 32'(acc), 32'h00);
    tick();  // edge 5
    check("maj_dout_e5",  32'(dout),     32'h01);
    check("maj_rise_e5",  32'(rise),     32'h01);
    check("maj_fall_e5",  32'(fall),     32'h00);
    check("maj_any_e5",   32'(any_edge), 32'h1);
    tick();  // edge 6
    check("maj_rise_e6",  32'(rise),     32'h00);
    check("maj_dout_e6",  32'(dout),     32'h01);
    din = 8'h00;
    repeat (4) tick();
    check("maj_fall_e4",  32'(dout),     32'h01);
    tick();
    check("maj_fall_dout", 32'(dout),    32'h00);
    check("maj_fall_pls",  32'(fall),    32'h01);
    tick();
    check("maj_fall_one",  32'(fall),    32'h00);

    // ---------------- glitch rejection, channel 3
    din = 8'h08;
    tick();
    din = 8'h00;
    acc = '0;
    for (int e = 0; e < 10; e++) begin
      tick();
      acc |= dout | rise | fall;
    end
    check("glitch1_reject", 32'(acc), 32'h00);

    din = 8'h08;
    tick(); tick();  // high for edges 1 and 2
    din = 8'h00;
    tick(); tick();  // edges 3, 4
    check("glitch2_e4_dout", 32'(dout), 32'h00);
    tick();          // edge 5
    check("glitch2_e5_dout", 32'(dout),     32'h08);
    check("glitch2_e5_rise", 32'(rise),     32'h08);
    check("glitch2_e5_any",  32'(any_edge), 32'h1);
    tick();          // edge 6
    check("glitch2_e6_dout", 32'(dout), 32'h08);
    check("glitch2_e6_edge", 32'({rise, fall}), 32'h0000);
    tick();          // edge 7
    check("glitch2_e7_dout", 32'(dout), 32'h00);
    check("glitch2_e7_fall", 32'(fall), 32'h08);
    tick();          // edge 8
    check("glitch2_e8_fall", 32'(fall), 32'h00);

    // ---------------- hysteresis, channel 5, pattern 1,1,0,1,1,...
    mode = 1'b1;
    acc = '0; acc5 = '0;
    for (int k = 1; k <= 11; k++) begin
      din[5]  = (k == 3) ? 1'b0 : 1'b1;
      din5[5] = (k == 3) ? 1'b0 : 1'b1;
      tick();
      if (k < 9) acc |= dout | rise;
      if (k == 9) begin
        check("hys3_dout_e9", 32'(dout), 32'h20);
        check("hys3_rise_e9", 32'(rise), 32'h20);
      end
      if (k == 10) check("hys3_rise_e10", 32'(rise), 32'h00);
      if (k < 11) acc5 |= dout5 | rise5;
      if (k == 11) begin
        check("hys5_dout_e11", 32'(dout5), 32'h20);
        check("hys5_rise_e11", 32'(rise5), 32'h20);
      end
    end
    check("hys3_early", 32'(acc),  32'h00);
    check("hys5_early", 32'(acc5), 32'h00);

    // Pattern 0,1,0 from DOUT=1 must not release the level
    acc = '0;
    for (int k = 1; k <= 12; k++) begin
      din[5]  = (k == 1 || k == 3) ? 1'b0 : 1'b1;
      din5[5] = din[5];
      tick();
      acc |= ((~dout) | (~dout5) | fall | fall5) & 8'h20;
    end
    check("hys_hold", 32'(acc), 32'h00);

    din = 8'h00; din5 = 8'h00;
    repeat (12) tick();
    check("hys_clear_dout",  32'(dout),  32'h00);
    check("hys_clear_dout5", 32'(dout5), 32'h00);
    mode = 1'b0;

    // ---------------- CE every 4 clocks; channel 1 steps, channel 2 toggles off-strobe
    acc = '0;
    for (int t = 1; t <= 12; t++) begin
      ce     = ((t % 4) == 0);
      din[1] = 1'b1;
      din[2] = (t == 3 || t == 4 || t == 7 || t == 8);
      tick();
      acc |= dout & 8'h04;
      if (t == 8) check("ce_e8_dout", 32'(dout), 32'h00);
      if (t == 9) begin
        check("ce_e9_dout", 32'(dout), 32'h02);
        check("ce_e9_rise", 32'(rise), 32'h02);
      end
      if (t == 10) begin
        check("ce_e10_rise", 32'(rise), 32'h00);
        check("ce_e10_dout", 32'(dout), 32'h02);
      end
    end
    check("ce_ignore_ch2", 32'(acc), 32'h00);
    ce = 1'b1; din = 8'h00;
    repeat (8) tick();

    // ---------------- MODE 1->0 with window 011 and DOUT=0, channel 6
    mode = 1'b1;
    din  = 8'h40;
    repeat (4) tick();
    check("mid_pre_dout", 32'(dout), 32'h00);
    mode = 1'b0;
    tick();
    check("mid_dout", 32'(dout),     32'h40);
    check("mid_rise", 32'(rise),     32'h40);
    check("mid_any",  32'(any_edge), 32'h1);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    din   = 8'h00;
    #1;
    check("mid_rst_dout", 32'(dout),     32'h00);
    check("mid_rst_rise", 32'(rise),     32'h00);
    check("mid_rst_fall", 32'(fall),     32'h00);
    check("mid_rst_any",  32'(any_edge), 32'h0);
    tick();
    check("mid_rst_hold", 32'(dout), 32'h00);
    rst_n = 1'b1;
    acc = '0;
    for (int e = 0; e < 6; e++) begin
      tick();
      acc |= dout | rise | fall;
    end
    check("mid_rst_state_cleared", 32'(acc), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
